// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a shadow/display
// register pair that commits only at frame boundaries.
module seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  hex_mode,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       BLANK    = 7'b1111111;

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                hex_mode;
    logic                lz_en;
  } disp_t;

  disp_t              shadow_q, disp_q, load_w;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pending_q, frame_end_q, frame_tick_q;
  logic [7:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic               frame_end;
  logic [DIGITS-1:0]  lz_blank;
  logic               zero_run;
  logic [3:0]         sel_nib;
  logic               sel_dp, sel_lz;

  function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
    case (code)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = hex ? 7'b0001000 : BLANK;
      4'hB:    glyph = hex ? 7'b0000011 : BLANK;
      4'hC:    glyph = hex ? 7'b1000110 : BLANK;
      4'hD:    glyph = hex ? 7'b0100001 : BLANK;
      4'hE:    glyph = hex ? 7'b0000110 : BLANK;
      default: glyph = hex ? 7'b0001110 : BLANK;
    endcase
  endfunction

  assign load_w    = {value, dp, hex_mode, lz_en};
  assign frame_end = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Leading-zero blanking scans down from the top digit; digit 0 is never blanked.
  // NOTE: blocking assignments are correct here: zero_run is a running value within one evaluation.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (disp_q.value[4*i +: 4] == 4'h0);
      lz_blank[i] = disp_q.lz_en & zero_run;
    end
  end

  always_comb begin
    sel_nib = 4'h0;
    sel_dp  = 1'b0;
    sel_lz  = 1'b0;
    an_d    = '1;
    seg_d   = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib = disp_q.value[4*i +: 4];
        sel_dp  = disp_q.dp[i];
        sel_lz  = lz_blank[i];
      end
    end
    if (cnt_q >= CNT_LIT) begin
      for (int i = 0; i < DIGITS; i++) an_d[i] = (idx_q != IDX_W'(i));
      seg_d = {~sel_dp, sel_lz ? BLANK : glyph(sel_nib, disp_q.hex_mode)};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      // frame_tick lines up with the first blanked output of digit 0.
      frame_end_q  <= frame_end;
      frame_tick_q <= frame_end_q;
      if (load) shadow_q <= load_w;
      if (frame_end && load)           disp_q <= load_w;
      else if (frame_end && pending_q) disp_q <= shadow_q;
      if (frame_end)  pending_q <= 1'b0;
      else if (load)  pending_q <= 1'b1;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, dwell 8, blank 2): expected
// per-cycle frames are queued on load and compared as the display scans them.
module tb_seg_scan_driver;

  logic        clk, rst, load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        hex_mode, lz_en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick, pending;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct {
    logic       tick;
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .hex_mode   (hex_mode),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge where frame_tick is seen (frame cycle 0).
  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = frame_tick;
    end
    check({tag, " tick"}, 32'(seen), 32'd1);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d,
                            input logic h, input logic l);
    value = v; dp = d; hex_mode = h; lz_en = l; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] s [4];
    exp_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        e.tick = (d == 0 && c == 0);
        e.an   = (c < 2) ? 4'hF : ~(4'b0001 << d);
        e.seg  = (c < 2) ? 8'hFF : s[d];
        sb.push_back(e);
      end
    end
  endtask

  // Called at the negedge of frame cycle 0; ends at frame cycle 31.
  task automatic check_frame(input string tag);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      if (k != 0) @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s d%0d c%0d", tag, k / 8, k % 8),
            {19'd0, frame_tick, an, seg}, {19'd0, e.tick, e.an, e.seg});
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp = '0; hex_mode = 1'b0; lz_en = 1'b0;

    // Reset and first lit cycle.
    repeat (3) begin
      @(negedge clk);
      check("rst seg/an", {20'd0, an, seg}, {20'd0, 4'hF, 8'hFF});
      check("rst tick/pending", {30'd0, frame_tick, pending}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post-rst blank 1", {20'd0, an, seg}, {20'd0, 4'hF, 8'hFF});
    @(negedge clk);
    check("post-rst blank 2", {20'd0, an, seg}, {20'd0, 4'hF, 8'hFF});
    @(negedge clk);
    check("first lit", {20'd0, an, seg}, {20'd0, 4'b1110, 8'hC0});

    // Scan order.
    wait_tick("scan pre");
    drive_load(16'h1234, 4'b0100, 1'b0, 1'b0);
    check("scan pending set", 32'(pending), 32'd1);
    push_frame(8'h99, 8'hB0, 8'h24, 8'hF9);
    wait_tick("scan");
    check("scan pending clear", 32'(pending), 32'd0);
    check_frame("scan");

    // Hex glyphs with leading-zero blanking, then hex disabled.
    wait_tick("hex pre");
    drive_load(16'h00AF, 4'b0000, 1'b1, 1'b1);
    push_frame(8'h8E, 8'h88, 8'hFF, 8'hFF);
    wait_tick("hex");
    check_frame("hex");
    wait_tick("nohex pre");
    drive_load(16'h00AF, 4'b0000, 1'b0, 1'b1);
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_tick("nohex");
    check_frame("nohex");

    // Tear-free: two loads in one frame, last wins at the boundary.
    wait_tick("tear pre");
    drive_load(16'h1111, 4'b0000, 1'b0, 1'b0);
    check("tear pending k1", 32'(pending), 32'd1);
    repeat (15) @(negedge clk);
    drive_load(16'h2222, 4'b0000, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    check("tear pending k30", {30'd0, frame_tick, pending}, 32'd1);
    @(negedge clk);
    check("tear pending k31", 32'(pending), 32'd0);
    push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);
    @(negedge clk);
    check_frame("tear");

    // Load coinciding with frame end commits directly; blanked digit keeps its dp.
    wait_tick("sim pre");
    repeat (30) @(negedge clk);
    drive_load(16'h0853, 4'b1001, 1'b0, 1'b1);
    check("sim pending k31", 32'(pending), 32'd0);
    push_frame(8'h30, 8'h92, 8'h80, 8'h7F);
    @(negedge clk);
    check("sim pending k32", 32'(pending), 32'd0);
    check_frame("sim");

    // Asynchronous reset mid-frame while digit 2 is lit, with pending data.
    wait_tick("arst pre");
    drive_load(16'h4444, 4'b0000, 1'b0, 1'b0);
    check("arst pending set", 32'(pending), 32'd1);
    repeat (17) @(negedge clk);
    check("arst idx2 lit", 32'(an), 32'(4'b1011));
    #2 rst = 1'b1;
    #1;
    check("arst seg/an", {20'd0, an, seg}, {20'd0, 4'hF, 8'hFF});
    check("arst tick/pending", {30'd0, frame_tick, pending}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    wait_tick("arst");
    check_frame("arst");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed N-digit 7-segment display driver that succeeds the single-digit combinational BCD decoder. It latches a packed nibble word and scans the digits one at a time, with per-digit decimal points and optional hex glyphs. It also provides leading-zero blanking, anti-ghosting blank intervals and tear-free frame-synchronous updates. It sits between the calculator datapath and the board's common-anode display pins.

## Interface
- DIGITS, 4: number of digits, 1..8; digit 0 is the least significant.
- REFRESH_DIV, 50000: clock cycles each digit is selected (dwell), ≥ 4.
- BLANK_CYC, 500: leading cycles of each dwell with all anodes off; must satisfy 1 ≤ BLANK_CYC < REFRESH_DIV.
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe that captures value/dp/hex_mode/lz_en into the shadow.
- value  in  4*DIGITS  packed nibbles; [3:0] = digit 0.
- dp  in  DIGITS  decimal point request per digit, 1 = lit.
- hex_mode  in  1  1 = codes 10..15 shown as A,b,C,d,E,F; 0 = codes 10..15 blanked.
- lz_en  in  1  1 = leading-zero blanking enabled.
- seg  out  8  active-low; bit0..6 = segments a..g, bit7 = dp.
- an  out  DIGITS  active-low digit enables.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- pending  out  1  shadow holds data not yet committed to display.

## Operation
- Decimal glyphs 0..9 use the existing decoder's segment set with active-low polarity: 0 → seg[6:0]=7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000.
- Hex glyphs: A=7'b0001000, b=7'b0000011, C=7'b1000110, d=7'b0100001, E=7'b0000110, F=7'b0001110.
- Blank glyph: 7'b1111111.
- Counters: cnt runs 0..REFRESH_DIV-1. idx advances 0..DIGITS-1 when cnt wraps, and itself wraps from DIGITS-1 back to 0.
- Frame end occurs when idx=DIGITS-1 and cnt=REFRESH_DIV-1.
- Shadow register: load copies all four inputs into the shadow and sets pending. Multiple loads within one frame are last-wins.
- Commit: at frame end, if pending, the display register takes the shadow contents and pending clears. If load and frame end fall in the same cycle, the newly loaded data commits directly and pending stays 0.
- Leading-zero blanking: digit i (i ≥ 1) is blanked when lz_en=1 and nibbles i..DIGITS-1 are all 0. Digit 0 is never LZ-blanked. The dp of a blanked digit is still shown.
- Output for the selected digit:
  - seg[6:0] = glyph of nibble idx, or blank.
  - seg[7] = ~dp[idx].
  - an = all ones except bit idx = 0, and only when cnt ≥ BLANK_CYC.
  - While cnt < BLANK_CYC: an = all ones and seg = 8'hFF.
- hex_mode and lz_en take effect only through the committed display register, never live.

## Timing
- Reset values: seg=8'hFF, an=all ones, frame_tick=0, pending=0, cnt=0, idx=0, display and shadow registers = 0 (dp=0, hex_mode=0, lz_en=0).
- seg, an and frame_tick are registered. Each reflects the cnt/idx/display state of the previous cycle (1-cycle latency).
- Digit dwell is exactly REFRESH_DIV cycles: BLANK_CYC blanked cycles, then REFRESH_DIV-BLANK_CYC lit cycles.
- Frame period is DIGITS*REFRESH_DIV cycles.
- frame_tick is high for the single cycle after frame end, in the same cycle the first blank output of digit 0 appears.
- A committed value first appears on seg during the first lit cycle of digit 0 in the next frame. No frame ever mixes old and new digits.
- pending rises the cycle after a load. It falls the cycle after the commit.
- rst asserted mid-frame forces all outputs to reset values immediately, without waiting for clk. Pending shadow data is discarded. Scanning restarts at idx=0, cnt=0 on the first clock after rst deasserts.
- DIGITS=1: idx is constant 0 and every dwell ends a frame.

## Test plan
Common bench settings: DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2, frame = 32 cycles.
- Reset → hold rst 3 cycles, then release → seg=8'hFF and an=4'hF during rst. First lit cycle is cycle 3 after release with an=4'b1110 and seg=8'hC0 (digit 0, dp off).
- Scan order → load value=16'h1234, dp=4'b0100, lz_en=0 → after commit, the dwells show, in order:
  - an=1110 with glyph 4;
  - an=1101 with glyph 3;
  - an=1011 with glyph 2 and seg[7]=0;
  - an=0111 with glyph 1.
  - Each dwell has 2 blank cycles before it lights.
- Hex and blanking → load 16'h00AF with hex_mode=1, lz_en=1 → digits 0 and 1 show F and A. Digits 3 and 2 show seg=8'hFF while their an bit is asserted. Repeating the load with hex_mode=0 makes digits 0 and 1 blank as well.
- Tear-free commit → load 16'h1111, then load 16'h2222 mid-frame → pending=1 until frame end. Only 2222 is ever displayed, starting at digit 0 of the next frame. frame_tick pulses exactly once per 32 cycles.
- Simultaneous load and frame end → assert load exactly at frame end → pending stays 0 and the new value is shown in the immediately following frame.
- Async reset mid-frame → assert rst between clock edges while idx=2 → an=4'hF and seg=8'hFF without waiting for a clock edge. After release, the display shows 0 on digit 0 and 0 on every other digit (lz_en=0).
